// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: FSM states, 2-bit counter encodings,
// the in-flight prediction record and the direction/target check.
package branch_resolver_pkg;

    localparam int unsigned IDX_W_DEFAULT = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } br_state_t;

    typedef enum logic [1:0] {
        STRONG_NOT  = 2'b00,
        WEAK_NOT    = 2'b01,
        WEAK_JUMP   = 2'b10,
        STRONG_JUMP = 2'b11
    } br_ctr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        jump;
        logic [31:0] target;
    } pred_entry_t;

    // Target only matters when the branch was actually taken.
    function automatic logic pred_correct(pred_entry_t e, logic taken, logic [31:0] target);
        return (taken == e.jump) && (!taken || (target == e.target));
    endfunction

endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// pred_fifo: synchronous FIFO of in-flight predictions with single-cycle clear.
module pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  pred_entry_t            din,
    output pred_entry_t            head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    pred_entry_t   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: checks committed branch outcomes against queued IF predictions,
// trains the predictor and redirects/flushes on mispredict. Optional: BRANCH_STATS_EN.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEFAULT,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,
    input  logic                   pred_valid_in,
    input  logic [31:0]            pred_pc_in,
    input  logic                   pred_jump_in,
    input  logic [31:0]            pred_target_in,
    output logic                   pred_ready_out,
    input  logic                   res_valid_in,
    input  logic                   res_taken_in,
    input  logic [31:0]            res_target_in,
    output logic                   upd_valid_out,
    output logic [IDX_W-1:0]       upd_idx_out,
    output logic                   upd_taken_out,
    output logic                   redirect_valid_out,
    output logic [31:0]            redirect_pc_out,
    output logic                   flush_out,
    output logic [$clog2(DEPTH):0] count_out
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]            stat_br_out,
    output logic [31:0]            stat_miss_out
`endif
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    br_state_t   state;
    br_state_t   state_nxt;
    pred_entry_t head;
    pred_entry_t in_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_nxt;
    logic        idle;
    logic        pop;
    logic        miss;
    logic        push;

    // A full FIFO still takes a push when the head retires correctly in the same cycle;
    // a mispredicting pop discards any same-cycle push as wrong-path.
    always_comb begin
        idle      = (state == ST_IDLE);
        pop       = rdy_in && idle && res_valid_in && !fifo_empty;
        miss      = pop && !pred_correct(head, res_taken_in, res_target_in);
        push      = rdy_in && idle && pred_valid_in && (!fifo_full || pop) && !miss;
        in_entry  = '{pc: pred_pc_in, jump: pred_jump_in, target: pred_target_in};
        count_nxt = miss ? '0 : (fifo_count + CW'(push) - CW'(pop));
        state_nxt = (idle && miss) ? ST_FLUSH : ST_IDLE;
    end

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .clear (miss),
        .push  (push),
        .pop   (pop),
        .din   (in_entry),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state              <= ST_IDLE;
            pred_ready_out     <= 1'b1;
            upd_valid_out      <= 1'b0;
            upd_idx_out        <= '0;
            upd_taken_out      <= 1'b0;
            redirect_valid_out <= 1'b0;
            redirect_pc_out    <= '0;
            flush_out          <= 1'b0;
        end else if (!rdy_in) begin
            upd_valid_out      <= 1'b0;
            redirect_valid_out <= 1'b0;
            flush_out          <= 1'b0;
        end else begin
            state              <= state_nxt;
            pred_ready_out     <= (state_nxt == ST_IDLE) && (count_nxt < CW'(DEPTH));
            upd_valid_out      <= pop;
            redirect_valid_out <= miss;
            flush_out          <= miss;
            if (pop) begin
                upd_idx_out   <= head.pc[IDX_W-1:0];
                upd_taken_out <= res_taken_in;
            end
            if (miss) begin
                redirect_pc_out <= res_taken_in ? res_target_in : (head.pc + 32'd4);
            end
        end
    end

    assign count_out = fifo_count;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stat_br_out   <= '0;
            stat_miss_out <= '0;
        end else if (rdy_in) begin
            if (pop)  stat_br_out   <= stat_br_out + 32'd1;
            if (miss) stat_miss_out <= stat_miss_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: queue-based reference model, directed then random stimulus.
module tb_branch_resolver;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic        jump;
        logic [31:0] target;
    } ent_t;

    typedef struct {
        logic [11:0] idx;
        logic        taken;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        pv = 1'b0;
    logic [31:0] ppc = '0;
    logic        pj = 1'b0;
    logic [31:0] ptg = '0;
    logic        rv = 1'b0;
    logic        rt = 1'b0;
    logic [31:0] rtg = '0;

    logic        pred_ready_out;
    logic        upd_valid_out;
    logic [11:0] upd_idx_out;
    logic        upd_taken_out;
    logic        redirect_valid_out;
    logic [31:0] redirect_pc_out;
    logic        flush_out;
    logic [3:0]  count_out;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_out;
    logic [31:0] stat_miss_out;
`endif

    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    ent_t m_q[$];
    exp_t exp_q[$];
    bit   m_flush = 1'b0;

    branch_resolver #(.IDX_W(12), .DEPTH(DEPTH)) dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .rdy_in             (rdy),
        .pred_valid_in      (pv),
        .pred_pc_in         (ppc),
        .pred_jump_in       (pj),
        .pred_target_in     (ptg),
        .pred_ready_out     (pred_ready_out),
        .res_valid_in       (rv),
        .res_taken_in       (rt),
        .res_target_in      (rtg),
        .upd_valid_out      (upd_valid_out),
        .upd_idx_out        (upd_idx_out),
        .upd_taken_out      (upd_taken_out),
        .redirect_valid_out (redirect_valid_out),
        .redirect_pc_out    (redirect_pc_out),
        .flush_out          (flush_out),
        .count_out          (count_out)
`ifdef BRANCH_STATS_EN
        ,
        .stat_br_out        (stat_br_out),
        .stat_miss_out      (stat_miss_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: apply one clock edge's worth of the resolver rules to the queue.
    task automatic model_step();
        int   sz;
        bit   popped;
        ent_t h;
        bit   ok;
        exp_t e;
        if (!rdy) return;
        if (m_flush) begin
            m_flush = 1'b0;
            return;
        end
        sz     = m_q.size();
        popped = rv && (sz > 0);
        if (popped) begin
            h  = m_q[0];
            ok = (rt == h.jump) && (!rt || (rtg == h.target));
            e.idx   = h.pc[11:0];
            e.taken = rt;
            e.redir = !ok;
            e.rpc   = rt ? rtg : h.pc + 32'd4;
            exp_q.push_back(e);
            if (!ok) begin
                m_q.delete();
                m_flush = 1'b1;
                return;
            end
            void'(m_q.pop_front());
        end
        if (pv && (sz < DEPTH || popped)) begin
            h.pc = ppc; h.jump = pj; h.target = ptg;
            m_q.push_back(h);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] pc, input logic j,
                         input logic [31:0] tg, input logic resv, input logic rtk,
                         input logic [31:0] rtgt);
        rdy = r; pv = v; ppc = pc; pj = j; ptg = tg; rv = resv; rt = rtk; rtg = rtgt;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic idle_cyc();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("count", 32'(count_out), 32'(m_q.size()));
            chk("ready", 32'(pred_ready_out), 32'(!m_flush && m_q.size() < DEPTH));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("upd_valid", 32'(upd_valid_out), 32'd1);
                chk("upd_idx", 32'(upd_idx_out), 32'(e.idx));
                chk("upd_taken", 32'(upd_taken_out), 32'(e.taken));
                chk("redirect_valid", 32'(redirect_valid_out), 32'(e.redir));
                chk("flush", 32'(flush_out), 32'(e.redir));
                if (e.redir) chk("redirect_pc", redirect_pc_out, e.rpc);
            end else begin
                chk("upd_idle", 32'(upd_valid_out), 32'd0);
                chk("redirect_idle", 32'(redirect_valid_out), 32'd0);
                chk("flush_idle", 32'(flush_out), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_pc;
        logic [31:0] r_tg;
        logic [31:0] r_rt;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_upd", 32'(upd_valid_out), 32'd0);
        chk("rst_redirect", 32'(redirect_valid_out), 32'd0);
        chk("rst_flush", 32'(flush_out), 32'd0);
        chk("rst_rpc", redirect_pc_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        mon_en = 1'b1;

        // 1: correct taken prediction
        drive(1, 1, 32'h100, 1, 32'h200, 0, 0, '0);
        chk("t1_count1", 32'(count_out), 32'd1);
        drive(1, 0, '0, 0, '0, 1, 1, 32'h200);
        chk("t1_idx", 32'(upd_idx_out), 32'h100);
        // 2: predicted not-taken, actually taken
        drive(1, 1, 32'h104, 0, 32'h108, 0, 0, '0);
        drive(1, 1, 32'h108, 0, '0, 1, 1, 32'h300);
        chk("t2_rpc", redirect_pc_out, 32'h300);
        chk("t2_ready", 32'(pred_ready_out), 32'd0);
        drive(1, 1, 32'h10C, 0, '0, 0, 0, '0);
        chk("t2_flush_drop", 32'(count_out), 32'd0);
        idle_cyc();
        // 3: pc+4 wraps
        drive(1, 1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, '0);
        drive(1, 0, '0, 0, '0, 1, 0, '0);
        chk("t3_wrap", redirect_pc_out, 32'h0);
        idle_cyc();
        // 4: fill, overflow, push+pop when full, drain
        for (int i = 0; i < DEPTH; i++) drive(1, 1, 32'h1000 + 32'(4 * i), 0, '0, 0, 0, '0);
        chk("t4_full", 32'(count_out), 32'd8);
        drive(1, 1, 32'h2000, 0, '0, 0, 0, '0);
        chk("t4_drop", 32'(count_out), 32'd8);
        drive(1, 1, 32'h2004, 0, '0, 1, 0, '0);
        chk("t4_pushpop", 32'(count_out), 32'd8);
        for (int i = 0; i < DEPTH; i++) drive(1, 0, '0, 0, '0, 1, 0, '0);
        // 5: resolve on empty, frozen push
        drive(1, 0, '0, 0, '0, 1, 1, 32'h500);
        drive(0, 1, 32'h600, 1, 32'h700, 0, 0, '0);
        chk("t5_frozen", 32'(count_out), 32'd0);
        // 6: async reset with entries in flight
        for (int i = 0; i < 3; i++) drive(1, 1, 32'h3000 + 32'(4 * i), 1, 32'h80, 0, 0, '0);
        chk("t6_count3", 32'(count_out), 32'd3);
        drive(1, 0, '0, 0, '0, 1, 0, '0);
        mon_en = 1'b0;
        pv = 1'b0; rv = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_count0", 32'(count_out), 32'd0);
        chk("t6_upd", 32'(upd_valid_out), 32'd0);
        chk("t6_redirect", 32'(redirect_valid_out), 32'd0);
        chk("t6_flush", 32'(flush_out), 32'd0);
        chk("t6_rpc", redirect_pc_out, 32'd0);
        chk("t6_idx", 32'(upd_idx_out), 32'd0);
        m_q.delete();
        exp_q.delete();
        m_flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        mon_en = 1'b1;

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            r_pc = $urandom() & 32'hFFFF_FFFC;
            r_tg = ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300;
            r_rt = ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300;
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0, r_pc,
                  $urandom_range(0, 1) != 0, r_tg, $urandom_range(0, 9) < 4,
                  $urandom_range(0, 1) != 0, r_rt);
        end
        idle_cyc();
        idle_cyc();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
